// File: rtl/ctu_clsp_rstreq_pkg.sv
// Shared types and defaults for the reference-clock reset-request sequencer.
// State encodings are one-hot; grant priority is tst > fc > wrm.
package ctu_clsp_rstreq_pkg;

  typedef enum logic [4:0] {
    RSTREQ_IDLE        = 5'b00001,
    RSTREQ_ASSERT      = 5'b00010,
    RSTREQ_WAIT_UNLOCK = 5'b00100,
    RSTREQ_WAIT_LOCK   = 5'b01000,
    RSTREQ_DONE        = 5'b10000
  } rstreq_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WRM  = 2'd1,
    GNT_FC   = 2'd2,
    GNT_TST  = 2'd3
  } rstreq_gnt_e;

  localparam logic [3:0]  HOLD_CNT_DEF    = 4'h8;
  localparam logic [15:0] LOCK_TO_CNT_DEF = 16'hFFFF;

  localparam int unsigned REQ_WRM = 0;
  localparam int unsigned REQ_FC  = 1;
  localparam int unsigned REQ_TST = 2;

  function automatic rstreq_gnt_e rstreq_pick(input logic [2:0] pend);
    rstreq_gnt_e g;
    g = GNT_NONE;
    if (pend[REQ_TST])      g = GNT_TST;
    else if (pend[REQ_FC])  g = GNT_FC;
    else if (pend[REQ_WRM]) g = GNT_WRM;
    return g;
  endfunction

  function automatic logic [2:0] rstreq_mask(input rstreq_gnt_e g);
    logic [2:0] m;
    m = 3'b000;
    case (g)
      GNT_WRM: m = 3'b001;
      GNT_FC:  m = 3'b010;
      GNT_TST: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ctu_clsp_rstreq_edge.sv
// Two-flop synchronizer, rising-edge detect and sticky pending bit for one
// jbus-domain request. Edge-to-pending latency is three reference clocks.
module ctu_clsp_rstreq_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  input  logic i_clr,
  output logic o_pend
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_pend;
  logic w_rise;

  assign w_rise = r_s2 & ~r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_s1   <= i_req;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      // A fresh edge coinciding with the grant re-arms the bit.
      r_pend <= (r_pend & ~i_clr) | w_rise;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/ctu_clsp_rstreq.sv
// Reset-request sequencer: arbitrates synced requests, drives one fixed-width
// reset level, then tracks PLL unlock/relock before acknowledging.
module ctu_clsp_rstreq
  import ctu_clsp_rstreq_pkg::*;
#(
  parameter logic [3:0]  HOLD_CNT    = HOLD_CNT_DEF,
  parameter logic [15:0] LOCK_TO_CNT = LOCK_TO_CNT_DEF
) (
  input  logic pll_raw_clk_out,
  input  logic io_pwron_rst_l,
  input  logic wrm_rst_req_jl,
  input  logic fc_req_jl,
  input  logic tst_rst_req_jl,
  input  logic pll_locked_jl,
  output logic wrm_rst_ref,
  output logic wrm_rst_fc_ref,
  output logic tst_rst_ref,
  output logic rst_busy_ref,
  output logic rst_ack_ref,
  output logic rst_to_err_ref
);

  logic [2:0]    w_pend;
  logic [2:0]    w_clr;
  logic          r_lock_s1;
  logic          r_lock_s2;
  rstreq_state_e r_state, w_state_d;
  rstreq_gnt_e   r_gnt, w_gnt_d;
  logic [3:0]    r_hold_cnt, w_hold_d;
  logic [15:0]   r_to_cnt, w_to_d;
  logic          w_to_expire;
  logic          r_wrm, r_fc, r_tst, r_busy, r_ack, r_err;
  logic          w_wrm_d, w_fc_d, w_tst_d, w_busy_d, w_ack_d, w_err_d;

  ctu_clsp_rstreq_edge u_edge_wrm (
    .i_clk   (pll_raw_clk_out),
    .i_rst_n (io_pwron_rst_l),
    .i_req   (wrm_rst_req_jl),
    .i_clr   (w_clr[REQ_WRM]),
    .o_pend  (w_pend[REQ_WRM])
  );

  ctu_clsp_rstreq_edge u_edge_fc (
    .i_clk   (pll_raw_clk_out),
    .i_rst_n (io_pwron_rst_l),
    .i_req   (fc_req_jl),
    .i_clr   (w_clr[REQ_FC]),
    .o_pend  (w_pend[REQ_FC])
  );

  ctu_clsp_rstreq_edge u_edge_tst (
    .i_clk   (pll_raw_clk_out),
    .i_rst_n (io_pwron_rst_l),
    .i_req   (tst_rst_req_jl),
    .i_clr   (w_clr[REQ_TST]),
    .o_pend  (w_pend[REQ_TST])
  );

  // The timeout window spans exactly LOCK_TO_CNT cycles and never wraps.
  assign w_to_expire = (r_to_cnt <= 16'd1);

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_hold_d  = r_hold_cnt;
    w_to_d    = r_to_cnt;
    w_clr     = 3'b000;
    w_err_d   = r_err;
    unique case (r_state)
      RSTREQ_IDLE: begin
        if (|w_pend) begin
          w_gnt_d   = rstreq_pick(w_pend);
          w_clr     = rstreq_mask(w_gnt_d);
          w_hold_d  = HOLD_CNT - 4'd1;
          w_state_d = RSTREQ_ASSERT;
        end
      end
      RSTREQ_ASSERT: begin
        if (r_hold_cnt == 4'd0) begin
          w_to_d    = LOCK_TO_CNT;
          w_state_d = RSTREQ_WAIT_UNLOCK;
        end else begin
          w_hold_d = r_hold_cnt - 4'd1;
        end
      end
      RSTREQ_WAIT_UNLOCK: begin
        if (!r_lock_s2) begin
          w_to_d    = LOCK_TO_CNT;
          w_state_d = RSTREQ_WAIT_LOCK;
        end else if (w_to_expire) begin
          w_err_d   = 1'b1;
          w_state_d = RSTREQ_DONE;
        end else begin
          w_to_d = r_to_cnt - 16'd1;
        end
      end
      RSTREQ_WAIT_LOCK: begin
        if (r_lock_s2) begin
          w_state_d = RSTREQ_DONE;
        end else if (w_to_expire) begin
          w_err_d   = 1'b1;
          w_state_d = RSTREQ_DONE;
        end else begin
          w_to_d = r_to_cnt - 16'd1;
        end
      end
      RSTREQ_DONE: begin
        w_gnt_d   = GNT_NONE;
        w_state_d = RSTREQ_IDLE;
      end
      default: begin
        w_gnt_d   = GNT_NONE;
        w_hold_d  = 4'd0;
        w_to_d    = 16'd0;
        w_state_d = RSTREQ_IDLE;
      end
    endcase

    w_wrm_d  = (w_state_d == RSTREQ_ASSERT) && (w_gnt_d == GNT_WRM);
    w_fc_d   = (w_state_d == RSTREQ_ASSERT) && (w_gnt_d == GNT_FC);
    w_tst_d  = (w_state_d == RSTREQ_ASSERT) && (w_gnt_d == GNT_TST);
    w_busy_d = (w_state_d != RSTREQ_IDLE);
    w_ack_d  = (w_state_d == RSTREQ_DONE);
  end

  always_ff @(posedge pll_raw_clk_out or negedge io_pwron_rst_l) begin
    if (!io_pwron_rst_l) begin
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_state    <= RSTREQ_IDLE;
      r_gnt      <= GNT_NONE;
      r_hold_cnt <= 4'd0;
      r_to_cnt   <= 16'd0;
      r_wrm      <= 1'b0;
      r_fc       <= 1'b0;
      r_tst      <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_lock_s1  <= pll_locked_jl;
      r_lock_s2  <= r_lock_s1;
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_hold_cnt <= w_hold_d;
      r_to_cnt   <= w_to_d;
      r_wrm      <= w_wrm_d;
      r_fc       <= w_fc_d;
      r_tst      <= w_tst_d;
      r_busy     <= w_busy_d;
      r_ack      <= w_ack_d;
      r_err      <= w_err_d;
    end
  end

  assign wrm_rst_ref    = r_wrm;
  assign wrm_rst_fc_ref = r_fc;
  assign tst_rst_ref    = r_tst;
  assign rst_busy_ref   = r_busy;
  assign rst_ack_ref    = r_ack;
  assign rst_to_err_ref = r_err;

endmodule

// File: tb/tb_ctu_clsp_rstreq.sv
// Directed bench for ctu_clsp_rstreq: a default instance plus a short-timeout
// instance used for the sticky timeout check.
module tb_ctu_clsp_rstreq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wrm_req = 1'b0, fc_req = 1'b0, tst_req = 1'b0, lock = 1'b1;
  logic wrm_o, fc_o, tst_o, busy_o, ack_o, err_o;
  logic t_wrm_req = 1'b0, t_fc_req = 1'b0, t_tst_req = 1'b0, t_lock = 1'b1;
  logic t_wrm_o, t_fc_o, t_tst_o, t_busy_o, t_ack_o, t_err_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ctu_clsp_rstreq u_dut (
    .pll_raw_clk_out (clk),
    .io_pwron_rst_l  (rst_n),
    .wrm_rst_req_jl  (wrm_req),
    .fc_req_jl       (fc_req),
    .tst_rst_req_jl  (tst_req),
    .pll_locked_jl   (lock),
    .wrm_rst_ref     (wrm_o),
    .wrm_rst_fc_ref  (fc_o),
    .tst_rst_ref     (tst_o),
    .rst_busy_ref    (busy_o),
    .rst_ack_ref     (ack_o),
    .rst_to_err_ref  (err_o)
  );

  ctu_clsp_rstreq #(
    .LOCK_TO_CNT (16'h0020)
  ) u_dut_to (
    .pll_raw_clk_out (clk),
    .io_pwron_rst_l  (rst_n),
    .wrm_rst_req_jl  (t_wrm_req),
    .fc_req_jl       (t_fc_req),
    .tst_rst_req_jl  (t_tst_req),
    .pll_locked_jl   (t_lock),
    .wrm_rst_ref     (t_wrm_o),
    .wrm_rst_fc_ref  (t_fc_o),
    .tst_rst_ref     (t_tst_o),
    .rst_busy_ref    (t_busy_o),
    .rst_ack_ref     (t_ack_o),
    .rst_to_err_ref  (t_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {tst_o, fc_o, wrm_o};
  endfunction

  // Wait for one sequence on the default instance and check its shape.
  task automatic serve(input logic [2:0] exp, input string tag);
    int n;
    int w;
    n = 0;
    while (outs() == 3'b000 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, " start"}, {29'd0, outs()}, {29'd0, exp});
    w = 0;
    while (outs() == exp && w < 20) begin
      chk({tag, " busy"}, {31'd0, busy_o}, 32'd1);
      w++;
      tick();
    end
    chk({tag, " width"}, w, 32'd8);
    chk({tag, " after"}, {29'd0, outs()}, 32'd0);
    lock = 1'b0;
    repeat (5) tick();
    lock = 1'b1;
    n = 0;
    while (!ack_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " ack"}, {31'd0, ack_o}, 32'd1);
    tick();
    chk({tag, " ack pulse"}, {31'd0, ack_o}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int w;
    int n;

    // Reset state
    repeat (3) tick();
    chk("rst outs", {29'd0, outs()}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst ack", {31'd0, ack_o}, 32'd0);
    chk("rst err", {31'd0, err_o}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post rst outs", {29'd0, outs()}, 32'd0);
    chk("post rst busy", {31'd0, busy_o}, 32'd0);

    // 1: warm reset, 4-cycle latency from request to output
    wrm_req = 1'b1;
    repeat (3) tick();
    chk("t1 latency", {31'd0, wrm_o}, 32'd0);
    tick();
    chk("t1 wrm high", {29'd0, outs()}, 32'd1);
    chk("t1 busy", {31'd0, busy_o}, 32'd1);
    w = 0;
    while (outs() == 3'b001 && w < 20) begin
      w++;
      tick();
    end
    chk("t1 width", w, 32'd8);
    chk("t1 after", {29'd0, outs()}, 32'd0);
    chk("t1 busy after", {31'd0, busy_o}, 32'd1);
    wrm_req = 1'b0;
    repeat (10) tick();
    chk("t1 no ack while locked", {31'd0, ack_o}, 32'd0);
    chk("t1 still busy", {31'd0, busy_o}, 32'd1);

    // 2: lock drops 100 cycles, then relocks
    lock = 1'b0;
    repeat (100) tick();
    chk("t2 no ack unlocked", {31'd0, ack_o}, 32'd0);
    chk("t2 busy unlocked", {31'd0, busy_o}, 32'd1);
    lock = 1'b1;
    repeat (2) tick();
    chk("t2 ack early", {31'd0, ack_o}, 32'd0);
    tick();
    chk("t2 ack", {31'd0, ack_o}, 32'd1);
    chk("t2 err", {31'd0, err_o}, 32'd0);
    tick();
    chk("t2 ack pulse", {31'd0, ack_o}, 32'd0);
    chk("t2 idle", {31'd0, busy_o}, 32'd0);

    // 3: simultaneous requests serialised tst, fc, wrm
    tst_req = 1'b1;
    fc_req  = 1'b1;
    wrm_req = 1'b1;
    repeat (2) tick();
    tst_req = 1'b0;
    fc_req  = 1'b0;
    wrm_req = 1'b0;
    serve(3'b100, "t3 tst");
    serve(3'b010, "t3 fc");
    serve(3'b001, "t3 wrm");
    repeat (20) tick();
    chk("t3 quiet", {29'd0, outs()}, 32'd0);
    chk("t3 quiet busy", {31'd0, busy_o}, 32'd0);

    // 4: repeated fc pulses during a warm reset merge into one sequence
    wrm_req = 1'b1;
    fork
      serve(3'b001, "t4 wrm");
      begin
        repeat (5) tick();
        repeat (3) begin
          fc_req = 1'b1;
          repeat (2) tick();
          fc_req = 1'b0;
          repeat (2) tick();
        end
      end
    join
    wrm_req = 1'b0;
    serve(3'b010, "t4 fc");
    repeat (30) tick();
    chk("t4 single fc", {29'd0, outs()}, 32'd0);
    chk("t4 single fc busy", {31'd0, busy_o}, 32'd0);
    chk("t4 err", {31'd0, err_o}, 32'd0);

    // 5: timeout in WAIT_UNLOCK with LOCK_TO_CNT = 32
    t_wrm_req = 1'b1;
    n = 0;
    while (!t_wrm_o && n < 20) begin
      tick();
      n++;
    end
    chk("t5 wrm high", {31'd0, t_wrm_o}, 32'd1);
    n = 0;
    while (t_wrm_o && n < 20) begin
      tick();
      n++;
    end
    t_wrm_req = 1'b0;
    chk("t5 pre err", {31'd0, t_err_o}, 32'd0);
    n = 0;
    while (!t_ack_o && n < 100) begin
      tick();
      n++;
    end
    chk("t5 unlock cycles", n, 32'd32);
    chk("t5 ack", {31'd0, t_ack_o}, 32'd1);
    chk("t5 err", {31'd0, t_err_o}, 32'd1);
    tick();
    chk("t5 ack pulse", {31'd0, t_ack_o}, 32'd0);
    repeat (10) tick();
    chk("t5 err sticky", {31'd0, t_err_o}, 32'd1);
    chk("t5 idle", {31'd0, t_busy_o}, 32'd0);
    chk("t5 main err", {31'd0, err_o}, 32'd0);

    // 6: reset mid-ASSERT
    wrm_req = 1'b1;
    n = 0;
    while (!wrm_o && n < 20) begin
      tick();
      n++;
    end
    chk("t6 wrm high", {31'd0, wrm_o}, 32'd1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("t6 async outs", {29'd0, outs()}, 32'd0);
    chk("t6 async busy", {31'd0, busy_o}, 32'd0);
    chk("t6 err cleared", {31'd0, t_err_o}, 32'd0);
    wrm_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6 idle outs", {29'd0, outs()}, 32'd0);
    chk("t6 idle busy", {31'd0, busy_o}, 32'd0);
    chk("t6 idle ack", {31'd0, ack_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Invariant: never more than one reset level high.
  always @(negedge clk) begin
    if (rst_n && ($countones(outs()) > 1)) begin
      bad++;
      total++;
      $error("FAIL onehot: got %0b want at most one bit", outs());
    end
  end

endmodule
